// File: rtl/reg_bank_4x_scoreboard_pkg.sv
// Shared parameters and helpers for the 4-entry register bank and its busy scoreboard.
package reg_bank_4x_scoreboard_pkg;

    // Width of each architectural register.
    localparam int registerDataWidth = 8;

    // Register index width and register count.
    // The index width matches the operand mux selector.
    localparam int REG_IDX_WIDTH    = 2;
    localparam int REG_COUNT        = 4;
    localparam int BUSY_COUNT_WIDTH = $clog2(REG_COUNT + 1);

    typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;
    typedef logic [REG_COUNT-1:0]     reg_mask_t;

    // One-hot mask for a register index. The mask is empty when en is low.
    function automatic reg_mask_t idx_to_mask(input logic en, input reg_idx_t idx);
        reg_mask_t mask;
        mask = '0;
        if (en) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

    // Number of set bits in a busy mask (0..REG_COUNT).
    function automatic logic [BUSY_COUNT_WIDTH-1:0] busy_popcount(input reg_mask_t mask);
        logic [BUSY_COUNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            n = n + BUSY_COUNT_WIDTH'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_bank_4x_scoreboard_busy_scoreboard.sv
// Per-register pending-write scoreboard.
// An issue marks a register busy, and a write retires it.
// The block also keeps a registered count of busy registers and a sticky
// flag for writes that had no pending producer.
module busy_scoreboard
    import reg_bank_4x_scoreboard_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [REG_IDX_WIDTH-1:0]    wr_addr,
    input  logic                        issue_en,
    input  logic [REG_IDX_WIDTH-1:0]    issue_addr,
    output logic [REG_COUNT-1:0]        busy,
    output logic [BUSY_COUNT_WIDTH-1:0] busy_count,
    output logic                        err_spurious_wr
);

    reg_mask_t                   r_busy;
    logic [BUSY_COUNT_WIDTH-1:0] r_busy_count;
    logic                        r_err_spurious_wr;

    reg_mask_t w_set_mask;
    reg_mask_t w_clr_mask;
    reg_mask_t w_busy_next;
    logic      w_spurious;

    // Next busy state. Set is applied after clear, so an issue and a write
    // to the same register on one edge leave that register busy.
    always_comb begin
        // NOTE: every signal driven here is assigned on every pass, so no path can hold an old value and infer a latch.
        w_set_mask  = idx_to_mask(issue_en, issue_addr);
        w_clr_mask  = idx_to_mask(wr_en, wr_addr);
        w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
        w_spurious  = wr_en && !r_busy[wr_addr]
                      && !(issue_en && (issue_addr == wr_addr));
    end

    // State update. The count is taken from the next busy value,
    // so the count always agrees with busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy            <= '0;
            r_busy_count      <= '0;
            r_err_spurious_wr <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
            r_busy       <= w_busy_next;
            r_busy_count <= busy_popcount(w_busy_next);
            if (w_spurious) begin
                r_err_spurious_wr <= 1'b1;
            end
        end
    end

    assign busy            = r_busy;
    assign busy_count      = r_busy_count;
    assign err_spurious_wr = r_err_spurious_wr;

endmodule

// File: rtl/reg_bank_4x_scoreboard.sv
// Four-entry register bank that feeds the operand 4-to-1 mux.
// The bank has a single write port and a busy scoreboard.
// hazard flags a consumer whose selected register still awaits a write.
module reg_bank_4x_scoreboard
    import reg_bank_4x_scoreboard_pkg::*;
#(
    parameter int                    DATA_WIDTH  = registerDataWidth,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [REG_IDX_WIDTH-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        issue_en,
    input  logic [REG_IDX_WIDTH-1:0]    issue_addr,
    input  logic [REG_IDX_WIDTH-1:0]    query_sel,
    output logic [DATA_WIDTH-1:0]       reg0_out,
    output logic [DATA_WIDTH-1:0]       reg1_out,
    output logic [DATA_WIDTH-1:0]       reg2_out,
    output logic [DATA_WIDTH-1:0]       reg3_out,
    output logic [REG_COUNT-1:0]        busy,
    output logic                        hazard,
    output logic [BUSY_COUNT_WIDTH-1:0] busy_count,
    output logic                        err_spurious_wr
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    reg_mask_t             w_busy;

    // Data registers. Only the addressed entry loads, and the others hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array resets entry by entry because it is four discrete flops. A RAM macro could not be cleared this way.
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (wr_en) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    busy_scoreboard u_busy_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .issue_en        (issue_en),
        .issue_addr      (issue_addr),
        .busy            (w_busy),
        .busy_count      (busy_count),
        .err_spurious_wr (err_spurious_wr)
    );

    // Mux inputs a, b, c and d, in that order.
    assign reg0_out = r_regs[0];
    assign reg1_out = r_regs[1];
    assign reg2_out = r_regs[2];
    assign reg3_out = r_regs[3];

    assign busy   = w_busy;
    // hazard is a direct lookup in busy, with no extra latency and no bypass.
    assign hazard = w_busy[query_sel];

endmodule

// File: tb/tb_reg_bank_4x_scoreboard.sv
// Self-checking bench for reg_bank_4x_scoreboard: table vectors, a mid-cycle
// reset sequence and random traffic against a reference model.
module tb_reg_bank_4x_scoreboard;

    localparam int DW = 8;

    typedef struct packed {
        logic          wr_en;
        logic [1:0]    wr_addr;
        logic [DW-1:0] wr_data;
        logic          issue_en;
        logic [1:0]    issue_addr;
        logic [1:0]    query_sel;
        logic [3:0]    exp_busy;
        logic [2:0]    exp_count;
        logic          exp_err;
        logic          exp_hazard;
        logic [1:0]    chk_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [3:0][DW-1:0] regs;
        logic [3:0]         reg_mask;
        logic [3:0]         busy;
        logic [2:0]         count;
        logic               err;
        logic               hazard;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          issue_en;
    logic [1:0]    issue_addr;
    logic [1:0]    query_sel;
    logic [DW-1:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0]    busy;
    logic          hazard;
    logic [2:0]    busy_count;
    logic          err_spurious_wr;

    logic [3:0][DW-1:0] dut_regs;
    assign dut_regs = {reg3_out, reg2_out, reg1_out, reg0_out};

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t vecs[20];

    // Reference model state for the random phase.
    logic [3:0][DW-1:0] m_regs;
    logic [3:0]         m_busy;
    logic               m_err;

    reg_bank_4x_scoreboard #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .issue_en        (issue_en),
        .issue_addr      (issue_addr),
        .query_sel       (query_sel),
        .reg0_out        (reg0_out),
        .reg1_out        (reg1_out),
        .reg2_out        (reg2_out),
        .reg3_out        (reg3_out),
        .busy            (busy),
        .hazard          (hazard),
        .busy_count      (busy_count),
        .err_spurious_wr (err_spurious_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic compare_exp(input exp_t e, input string tag);
        check($sformatf("%s busy", tag), 64'(busy), 64'(e.busy));
        check($sformatf("%s busy_count", tag), 64'(busy_count), 64'(e.count));
        check($sformatf("%s err", tag), 64'(err_spurious_wr), 64'(e.err));
        check($sformatf("%s hazard", tag), 64'(hazard), 64'(e.hazard));
        for (int i = 0; i < 4; i++) begin
            if (e.reg_mask[i]) begin
                check($sformatf("%s reg%0d", tag, i), 64'(dut_regs[i]), 64'(e.regs[i]));
            end
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] wa, input logic [DW-1:0] wd,
                         input logic ie, input logic [1:0] ia, input logic [1:0] qs);
        @(negedge clk);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        query_sel  = qs;
    endtask

    task automatic edge_and_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check($sformatf("%s queue_empty", tag), 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            compare_exp(e, tag);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s reg0", tag), 64'(reg0_out), 64'(0));
        check($sformatf("%s reg1", tag), 64'(reg1_out), 64'(0));
        check($sformatf("%s reg2", tag), 64'(reg2_out), 64'(0));
        check($sformatf("%s reg3", tag), 64'(reg3_out), 64'(0));
        check($sformatf("%s busy", tag), 64'(busy), 64'(0));
        check($sformatf("%s busy_count", tag), 64'(busy_count), 64'(0));
        check($sformatf("%s err", tag), 64'(err_spurious_wr), 64'(0));
        check($sformatf("%s hazard", tag), 64'(hazard), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0] nb;
        logic       ne;
        int         pc;

        // Fields: wr_en wr_addr wr_data issue_en issue_addr query_sel | busy count err hazard chk_addr data
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 4'b0100, 3'd1, 1'b0, 1'b1, 2'd2, 8'h00};
        vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 4'b0100, 3'd1, 1'b0, 1'b1, 2'd2, 8'h00};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 4'b0100, 3'd1, 1'b0, 1'b1, 2'd2, 8'h00};
        vecs[3]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd2, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd2, 8'hA5};
        vecs[4]  = '{1'b1, 2'd1, 8'h3C, 1'b1, 2'd1, 2'd1, 4'b0010, 3'd1, 1'b0, 1'b1, 2'd1, 8'h3C};
        vecs[5]  = '{1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd1, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1, 8'h11};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 4'b0001, 3'd1, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3, 4'b0011, 3'd2, 1'b0, 1'b0, 2'd1, 8'h11};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 4'b0111, 3'd3, 1'b0, 1'b1, 2'd2, 8'hA5};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 4'b1111, 3'd4, 1'b0, 1'b1, 2'd3, 8'h00};
        vecs[10] = '{1'b1, 2'd2, 8'h5A, 1'b1, 2'd1, 2'd2, 4'b1011, 3'd3, 1'b0, 1'b0, 2'd2, 8'h5A};
        vecs[11] = '{1'b1, 2'd0, 8'hC3, 1'b1, 2'd2, 2'd0, 4'b1110, 3'd3, 1'b0, 1'b0, 2'd0, 8'hC3};
        vecs[12] = '{1'b1, 2'd2, 8'h99, 1'b0, 2'd0, 2'd2, 4'b1010, 3'd2, 1'b0, 1'b0, 2'd2, 8'h99};
        vecs[13] = '{1'b1, 2'd3, 8'hEE, 1'b0, 2'd0, 2'd3, 4'b0010, 3'd1, 1'b0, 1'b0, 2'd3, 8'hEE};
        vecs[14] = '{1'b1, 2'd3, 8'h7F, 1'b0, 2'd0, 2'd1, 4'b0010, 3'd1, 1'b1, 1'b1, 2'd3, 8'h7F};
        vecs[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 4'b1010, 3'd2, 1'b1, 1'b1, 2'd3, 8'h7F};
        vecs[16] = '{1'b1, 2'd1, 8'h01, 1'b0, 2'd0, 2'd1, 4'b1000, 3'd1, 1'b1, 1'b0, 2'd1, 8'h01};
        vecs[17] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 4'b1000, 3'd1, 1'b1, 1'b1, 2'd0, 8'hC3};
        vecs[18] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 4'b1000, 3'd1, 1'b1, 1'b1, 2'd3, 8'h7F};
        vecs[19] = '{1'b1, 2'd3, 8'h0D, 1'b1, 2'd0, 2'd0, 4'b0001, 3'd1, 1'b1, 1'b1, 2'd3, 8'h0D};

        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = 2'd0;
        query_sel  = 2'd0;
        #12;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        // Table vectors: the expected result is queued at drive time and popped after the edge.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                  vecs[i].issue_en, vecs[i].issue_addr, vecs[i].query_sel);
            e          = '0;
            e.busy     = vecs[i].exp_busy;
            e.count    = vecs[i].exp_count;
            e.err      = vecs[i].exp_err;
            e.hazard   = vecs[i].exp_hazard;
            e.reg_mask = 4'b0001 << vecs[i].chk_addr;
            e.regs[vecs[i].chk_addr] = vecs[i].exp_data;
            exp_q.push_back(e);
            edge_and_check($sformatf("vec%0d", i));
        end

        // All registers hold nonzero data here. Reset is asserted mid-cycle
        // with a write and an issue pending, and it must clear immediately.
        #2;
        reset      = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 2'd1;
        wr_data    = 8'hFF;
        issue_en   = 1'b1;
        issue_addr = 2'd2;
        query_sel  = 2'd2;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_held_edge");
        @(negedge clk);
        reset    = 1'b0;
        wr_en    = 1'b0;
        issue_en = 1'b0;

        // Random traffic checked against the reference model.
        m_regs = '0;
        m_busy = '0;
        m_err  = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            nb = m_busy;
            ne = m_err;
            if (wr_en) begin
                if (!m_busy[wr_addr] && !(issue_en && issue_addr == wr_addr)) begin
                    ne = 1'b1;
                end
                m_regs[wr_addr] = wr_data;
                nb[wr_addr] = 1'b0;
            end
            if (issue_en) begin
                nb[issue_addr] = 1'b1;
            end
            m_busy = nb;
            m_err  = ne;
            pc = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_busy[k]) pc++;
            end
            e.regs     = m_regs;
            e.reg_mask = 4'b1111;
            e.busy     = m_busy;
            e.count    = 3'(pc);
            e.err      = m_err;
            e.hazard   = m_busy[query_sel];
            exp_q.push_back(e);
            edge_and_check($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
